seq_alu: RTL

- Parametrised, registered ALU; next generation of the core's 8-bit combinational ALU.
- Adds three things:
  - operand width set by parameter;
  - persistent flag register, with carry chaining for multi-word ADC/SBC;
  - multi-cycle shift-add multiplier.
- Sits between register file and writeback; operations are handed over with a valid/ready handshake.

---
 rtl/seq_alu.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered WIDTH-bit ALU with persistent flags and
// a shift-add multiplier behind a valid/ready handshake.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             sign
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_ADC  = 3'd3;
  localparam logic [2:0] OP_SBC  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             n_q, n_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] b_op;
  logic             c_in;
  logic [WIDTH:0]   sum;
  logic             v_arith;
  logic [WIDTH-1:0] alu_res;
  logic [PW-1:0]    acc_nxt;

  assign in_ready = (state_q != S_MUL);
  assign accept   = in_valid & in_ready;

  // Subtraction is a + ~b + carry-in, so carry out means "no borrow".
  always_comb begin
    b_op = b;
    c_in = 1'b0;
    unique case (op)
      OP_SUB: begin
        b_op = ~b;
        c_in = 1'b1;
      end
      OP_ADC: c_in = c_q;
      OP_SBC: begin
        b_op = ~b;
        c_in = c_q;
      end
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, c_in};
    v_arith = (a[WIDTH-1] == b_op[WIDTH-1]) &&
              (sum[WIDTH-1] != a[WIDTH-1]);
  end

  always_comb begin
    alu_res = b;
    unique case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: alu_res = sum[WIDTH-1:0];
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      default: alu_res = b;
    endcase
  end

  assign acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    z_d         = z_q;
    c_d         = c_q;
    v_d         = v_q;
    n_d         = n_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            z_d         = (alu_res == '0);
            n_d         = alu_res[WIDTH-1];
            if (op inside {OP_ADD, OP_SUB, OP_ADC, OP_SBC}) begin
              c_d = sum[WIDTH];
              v_d = v_arith;
            end
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = acc_nxt[WIDTH-1:0];
          result_hi_d = acc_nxt[PW-1:WIDTH];
          z_d         = (acc_nxt == '0);
          n_d         = acc_nxt[PW-1];
          c_d         = (acc_nxt[PW-1:WIDTH] != '0);
          v_d         = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
      n_q         <= n_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = z_q;
  assign carry     = c_q;
  assign overflow  = v_q;
  assign sign      = n_q;

endmodule
